mem_stage: RTL
==============

Name: mem_stage

Overview:
- Consumer of the EX stage's ex_data bundle. Holds the EX/MEM pipeline register.
- Drives the data-memory request/acknowledge interface and performs store byte-lane steering and load extraction/extension.
- Emits a registered bundle toward write-back.
- Sits between ex and the write-back stage, and is the only block in the core that talks to data memory.

Parameters:
- EX_W, 80, width of ex_data bundle (`EX_DATA).
- MS_W, 74, width of ms_data bundle (`MS_DATA).

Ports:
- clk  input  1  core clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- es_valid  input  1  ex_data holds a valid instruction.
- ex_data  input  80  {MemWrite, MemRead, RegWrite, MemtoReg[3:0], Mem_mode[2:0], Mem_read_us, data2[31:0], rd[4:0], result[31:0]}, MSB first.
- ms_allowin  output  1  stage accepts ex_data this cycle.
- data_req  output  1  memory request valid.
- data_we  output  1  1 = store, 0 = load.
- data_wstrb  output  4  byte enables for stores; 0 for loads.
- data_addr  output  32  byte address (= latched result).
- data_wdata  output  32  lane-replicated store data.
- data_ack  input  1  memory accepts and completes the request this cycle; rdata valid the same cycle for loads.
- data_rdata  input  32  load data.
- ms_valid  output  1  ms_data valid toward write-back.
- ws_allowin  input  1  write-back accepts ms_data.
- ms_data  output  74  {RegWrite, MemtoReg[3:0], rd[4:0], result[31:0], load_data[31:0]}.
- ms_misalign  output  1  one-cycle pulse when an access is dropped.

Behaviour:

Encodings and field rules:
- Mem_mode is one-hot: 3'b001 byte, 3'b010 half, 3'b100 word. Mem_read_us=1 selects zero-extension, 0 selects sign-extension.
- Memory op is MemRead|MemWrite. MemWrite has priority if both are set.

FSM states: IDLE, REQ, DONE. Reset puts the FSM in IDLE.
- Reset values: ms_valid=0, data_req=0, ms_misalign=0, ms_data=0, data_wstrb=0, data_we=0.
- ms_allowin = (state==IDLE) | (state==DONE & ws_allowin).
- Accept on es_valid & ms_allowin: latch the full ex_data bundle.
  - Memory op that is legal -> REQ.
  - Otherwise -> DONE with load_data=0.
- REQ:
  - data_req=1; data_addr, data_we, data_wstrb and data_wdata are held stable until data_ack.
  - On data_ack: capture extracted load data (loads) -> DONE. Stores also -> DONE, with load_data=0.
  - Unbounded wait is allowed.
- DONE:
  - ms_valid=1, and ms_data is held stable until ws_allowin.
  - On ws_allowin with no new accept -> IDLE.
  - On ws_allowin with a same-cycle accept -> REQ or DONE per the new bundle. This gives back-to-back throughput of 1/cycle for non-memory ops.

Latency:
- Non-memory op accepted at cycle N: ms_valid at N+1.
- Memory op accepted at N: data_req at N+1. With data_ack at cycle M, ms_valid at M+1.

Store steering (off = result[1:0]):
- Byte: wdata = {4{data2[7:0]}}, wstrb = 4'b0001 << off.
- Half: wdata = {2{data2[15:0]}}, wstrb = 4'b0011 (off=0) or 4'b1100 (off=2).
- Word: wdata = data2, wstrb = 4'b1111.

Load extraction:
- Byte: rdata[8*off+7 : 8*off].
- Half: rdata[16*off[1]+15 : 16*off[1]].
- Word: whole word.
- Extend to 32 bits per Mem_read_us.

Illegal access:
- Applies to a half with off[0]=1, a word with off!=0, or a non-one-hot Mem_mode on a memory op.
- No request is issued. ms_misalign pulses for 1 cycle in the cycle after accept.
- FSM -> DONE with RegWrite forced to 0 in ms_data.

Edge cases:
- data_ack outside REQ is ignored.
- Reset mid-REQ: data_req drops in the next cycle, FSM goes to IDLE, and the pending transaction is abandoned.
- es_valid while not allowin: ex_data is not sampled; upstream holds it.

Test Plan:
- ALU op result=0x0000_1234, rd=5, RegWrite=1, es_valid for 3 consecutive cycles with ws_allowin=1 -> ms_valid high for 3 consecutive cycles, ms_data carries result 0x1234, rd 5, load_data 0, and no data_req.
- Store byte data2=0x0000_00AB, result=0x100 + 3 -> data_req with data_we=1, data_wstrb=4'b1000, data_wdata=0xABAB_ABAB; ack after 4 cycles -> ms_valid exactly 1 cycle later.
- Load half signed at address 0x202 with rdata=0x8001_0000 -> load_data=0xFFFF_8001. Same load with Mem_read_us=1 -> 0x0000_8001. Byte load at off=1 with rdata=0x0000_7F00 -> 0x0000_007F.
- Word load at address 0x101 -> no data_req, ms_misalign pulse, ms_data RegWrite=0, ms_valid the next cycle.
- ws_allowin held 0 for 5 cycles while in DONE -> ms_data stable, ms_allowin=0, ex_data changes ignored. Release ws_allowin with es_valid=1 -> new op accepted the same cycle.
- rst asserted while in REQ before ack -> data_req=0 and ms_valid=0 the next cycle. A late data_ack is ignored, and the next op proceeds normally.

Source files
------------

// File: rtl/mem_stage.sv
// EX/MEM pipeline register plus data-memory front end: store lane steering,
// load extraction/extension, and the handshake toward write-back.
module mem_stage #(
   parameter int EX_W = 80,
   parameter int MS_W = 74
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            es_valid,
   input  logic [EX_W-1:0] ex_data,
   output logic            ms_allowin,
   output logic            data_req,
   output logic            data_we,
   output logic [3:0]      data_wstrb,
   output logic [31:0]     data_addr,
   output logic [31:0]     data_wdata,
   input  logic            data_ack,
   input  logic [31:0]     data_rdata,
   output logic            ms_valid,
   input  logic            ws_allowin,
   output logic [MS_W-1:0] ms_data,
   output logic            ms_misalign
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t state, state_nx;

   // Fields of the incoming bundle
   logic        ex_mem_write, ex_mem_read, ex_reg_write, ex_read_us;
   logic [3:0]  ex_mem_to_reg;
   logic [2:0]  ex_mem_mode;
   logic [31:0] ex_data2, ex_result;
   logic [4:0]  ex_rd;
   logic        ex_mem_op, ex_onehot, ex_illegal, accept;

   // Latched EX/MEM register
   logic        mem_write_q, reg_write_q, read_us_q, misalign_q;
   logic [3:0]  mem_to_reg_q;
   logic [2:0]  mem_mode_q;
   logic [31:0] data2_q, result_q, load_data_q;
   logic [4:0]  rd_q;

   logic [1:0]  off;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_ext, wdata_c;
   logic [3:0]  wstrb_c;

   assign {ex_mem_write, ex_mem_read, ex_reg_write, ex_mem_to_reg, ex_mem_mode,
           ex_read_us, ex_data2, ex_rd, ex_result} = ex_data;

   assign ex_mem_op  = ex_mem_write | ex_mem_read;
   assign ex_onehot  = (ex_mem_mode == 3'b001) | (ex_mem_mode == 3'b010) |
                       (ex_mem_mode == 3'b100);
   assign ex_illegal = ex_mem_op & (~ex_onehot |
                       ((ex_mem_mode == 3'b010) & ex_result[0]) |
                       ((ex_mem_mode == 3'b100) & (ex_result[1:0] != 2'b00)));

   assign ms_allowin = (state == IDLE) | ((state == DONE) & ws_allowin);
   assign accept     = es_valid & ms_allowin;

   // NOTE: combinational blocks assign every output a default first so no latch is inferred.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (accept) state_nx = (ex_mem_op & ~ex_illegal) ? REQ : DONE;
         REQ:  if (data_ack) state_nx = DONE;
         DONE: if (ws_allowin) begin
            if (accept) state_nx = (ex_mem_op & ~ex_illegal) ? REQ : DONE;
            else        state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign off = result_q[1:0];

   always_comb begin
      byte_sel = data_rdata[7:0];
      case (off)
         2'd1:    byte_sel = data_rdata[15:8];
         2'd2:    byte_sel = data_rdata[23:16];
         2'd3:    byte_sel = data_rdata[31:24];
         default: byte_sel = data_rdata[7:0];
      endcase
      half_sel = off[1] ? data_rdata[31:16] : data_rdata[15:0];
      case (mem_mode_q)
         3'b001:  load_ext = read_us_q ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         3'b010:  load_ext = read_us_q ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
         default: load_ext = data_rdata;
      endcase
   end

   always_comb begin
      wstrb_c = 4'b0000;
      wdata_c = data2_q;
      case (mem_mode_q)
         3'b001: begin
            wstrb_c = 4'b0001 << off;
            wdata_c = {4{data2_q[7:0]}};
         end
         3'b010: begin
            wstrb_c = off[1] ? 4'b1100 : 4'b0011;
            wdata_c = {2{data2_q[15:0]}};
         end
         3'b100:  wstrb_c = 4'b1111;
         default: wstrb_c = 4'b0000;
      endcase
   end

   assign data_req    = (state == REQ);
   assign data_we     = data_req & mem_write_q;
   assign data_wstrb  = data_we ? wstrb_c : 4'b0000;
   assign data_wdata  = wdata_c;
   assign data_addr   = result_q;
   assign ms_valid    = (state == DONE);
   assign ms_misalign = misalign_q;
   assign ms_data     = {reg_write_q, mem_to_reg_q, rd_q, result_q, load_data_q};

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         mem_write_q  <= 1'b0;
         reg_write_q  <= 1'b0;
         read_us_q    <= 1'b0;
         mem_to_reg_q <= 4'b0;
         mem_mode_q   <= 3'b0;
         data2_q      <= 32'b0;
         result_q     <= 32'b0;
         rd_q         <= 5'b0;
         load_data_q  <= 32'b0;
         misalign_q   <= 1'b0;
      end else begin
         state      <= state_nx;
         misalign_q <= accept & ex_illegal;
         if (accept) begin
            mem_write_q  <= ex_mem_write;
            reg_write_q  <= ex_reg_write & ~ex_illegal;
            read_us_q    <= ex_read_us;
            mem_to_reg_q <= ex_mem_to_reg;
            mem_mode_q   <= ex_mem_mode;
            data2_q      <= ex_data2;
            result_q     <= ex_result;
            rd_q         <= ex_rd;
            load_data_q  <= 32'b0;
         end else if ((state == REQ) && data_ack && !mem_write_q) begin
            load_data_q <= load_ext;
         end
      end
   end

endmodule
